// File: rtl/wb_dmem_if.sv
// ---------------------------------------------------------------------------
// wb_dmem_if
//   Wishbone classic bus bundle between the MEM-stage master and wb_dmem.
//   Signal names carry the slave-side direction suffix so they line up with
//   the data-memory port list.
//   master : drives cyc/stb/we/sel/addr/dat_i, receives dat_o/ack/err
//   slave  : receives cyc/stb/we/sel/addr/dat_i, drives dat_o/ack/err
// ---------------------------------------------------------------------------
interface wb_dmem_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_dmem.sv
// ---------------------------------------------------------------------------
// wb_dmem
//   Wishbone classic slave data memory. Word-organised RAM with byte-lane
//   write enables, a programmable number of wait states and its own address
//   window decode (out-of-window requests terminate with err).
//
//   Parameters
//     BASE_ADDR    byte address of word 0 (4-byte aligned)
//     DEPTH_WORDS  number of 32-bit words, power of two
//     WAIT_STATES  extra cycles between request sample and ack/err (0..15)
//
//   Ports
//     clk_i  clock, all state on the rising edge
//     rst_i  synchronous active-high reset
//     wbs    wb_dmem_if.slave: cyc/stb/we/sel/addr/dat_i in, dat_o/ack/err out
//
//   Optional feature
//     DMEM_ALIGN_CHECK_EN : when defined, misaligned addresses and
//     non-naturally-aligned byte-lane patterns also terminate with err.
// ---------------------------------------------------------------------------
module wb_dmem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  wb_dmem_if.slave wbs
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33-bit end-of-window so a window touching 4 GiB cannot wrap to zero
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    wait_cnt;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdat_q;
  logic [31:0]   rdat_q;
  logic          in_window;
  logic          req_bad;
  logic          commit;
  logic [AW-1:0] word_idx;

  logic [31:0]   mem [DEPTH_WORDS];

  // Decode of the latched request; stable from WAIT through RESP.
  always_comb begin
    in_window = ({1'b0, addr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_q} < LIMIT);
    word_idx  = AW'((addr_q - BASE_ADDR) >> 2);
`ifdef DMEM_ALIGN_CHECK_EN
    req_bad   = !in_window || (addr_q[1:0] != 2'b00) ||
                !(sel_q inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0011, 4'b1100, 4'b1111});
`else
    req_bad   = !in_window;
`endif
  end

  // Next-state logic. A dropped cyc while waiting abandons the request.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // RAM access happens exactly on the WAIT->RESP edge for a good request
    commit = (state == ST_WAIT) && (state_nxt == ST_RESP) && !req_bad;
  end

  // State register, request latch and read-data register.
  // rdat_q is loaded only for a successful read, so it is zero in every
  // other cycle including RESP of writes and errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdat_q   <= 32'd0;
      rdat_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && (state_nxt == ST_WAIT)) begin
        we_q     <= wbs.wbs_we_i;
        sel_q    <= wbs.wbs_sel_i;
        addr_q   <= wbs.wbs_addr_i;
        wdat_q   <= wbs.wbs_dat_i;
        wait_cnt <= 4'(WAIT_STATES);
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      rdat_q <= (commit && !we_q) ? mem[word_idx] : 32'd0;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem[word_idx][8*i +: 8] <= wdat_q[8*i +: 8];
        end
      end
    end
  end

  assign wbs.wbs_ack_o = (state == ST_RESP) && !req_bad;
  assign wbs.wbs_err_o = (state == ST_RESP) &&  req_bad;
  assign wbs.wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_dmem.sv
// ---------------------------------------------------------------------------
// tb_wb_dmem
//   Bench for wb_dmem. Two instances share one clock: dut index 0 has no
//   wait states, dut index 1 has three. A word-array model of each memory
//   predicts ack/err/read data/latency for every transaction.
//   Honours DMEM_ALIGN_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_wb_dmem;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  wb_dmem_if bus_a ();
  wb_dmem_if bus_b ();

  wb_dmem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .wbs   (bus_a.slave)
  );

  wb_dmem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .wbs   (bus_b.slave)
  );

  // Drive the master side of one bus
  task automatic drive(input int d, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] dat);
    if (d == 0) begin
      bus_a.wbs_cyc_i = cyc; bus_a.wbs_stb_i = stb; bus_a.wbs_we_i = we;
      bus_a.wbs_sel_i = sel; bus_a.wbs_addr_i = addr; bus_a.wbs_dat_i = dat;
    end else begin
      bus_b.wbs_cyc_i = cyc; bus_b.wbs_stb_i = stb; bus_b.wbs_we_i = we;
      bus_b.wbs_sel_i = sel; bus_b.wbs_addr_i = addr; bus_b.wbs_dat_i = dat;
    end
  endtask

  task automatic sample(input int d, output logic ack, output logic err, output logic [31:0] dat);
    if (d == 0) begin
      ack = bus_a.wbs_ack_o; err = bus_a.wbs_err_o; dat = bus_a.wbs_dat_o;
    end else begin
      ack = bus_b.wbs_ack_o; err = bus_b.wbs_err_o; dat = bus_b.wbs_dat_o;
    end
  endtask

  // One complete transaction; lat counts edges after the sampling edge until
  // ack/err is seen (-1 on timeout). Returns in the IDLE cycle after RESP.
  task automatic do_txn(input int d, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] dat,
                        output logic ack, output logic err, output logic [31:0] rdat,
                        output int lat);
    logic a, e;
    logic [31:0] r;
    ack = 1'b0; err = 1'b0; rdat = 32'd0; lat = -1;
    @(negedge clk);
    drive(d, 1'b1, 1'b1, we, sel, addr, dat);
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      sample(d, a, e, r);
      if (a || e) begin
        ack = a; err = e; rdat = r; lat = k;
        break;
      end
    end
    drive(d, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Address-window / alignment rule
  function automatic bit exp_bad(input logic [31:0] a, input logic [3:0] s);
    longint unsigned la = longint'(a);
    longint unsigned lb = longint'(BASE);
    bit bad = (la < lb) || (la >= lb + 4 * DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] lo = a[1:0];
    if (lo != 2'b00) bad = 1'b1;
    if (!(s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) bad = 1'b1;
`endif
    return bad;
  endfunction

  // Predict the outcome of a transaction and update the memory model
  task automatic model_txn(input int d, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] dat,
                           output logic eack, output logic eerr, output logic [31:0] edat,
                           output int elat);
    int idx;
    elat = (d == 0) ? 1 : 4;
    eerr = exp_bad(addr, sel);
    eack = !eerr;
    edat = 32'd0;
    if (!eerr) begin
      idx = int'((addr - BASE) / 4);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (sel[i]) mdl[d][idx][8*i +: 8] = dat[8*i +: 8];
      end else begin
        edat = mdl[d][idx];
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      1:       return BASE - 32'd4 - 32'(4 * $urandom_range(0, 3));
      2:       return BASE + 32'($urandom_range(0, 3));
      3:       return BASE + 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 3));
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic test_reset();
    logic a, e;
    logic [31:0] r;
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sample(d, a, e, r);
      tests_run++;
      if ({a, e} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL reset_ack_err dut%0d: got %b, want 00", d, {a, e});
      end
      tests_run++;
      if (r !== 32'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_dat dut%0d: got %h, want 0", d, r);
      end
    end
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Give every word a known value
  task automatic test_fill();
    logic a, e, ea, ee;
    logic [31:0] r, er, v;
    int lat, el;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < DEPTH; w++) begin
        v = $urandom;
        model_txn(d, 1'b1, 4'hF, BASE + 32'(4 * w), v, ea, ee, er, el);
        do_txn(d, 1'b1, 4'hF, BASE + 32'(4 * w), v, a, e, r, lat);
        tests_run++;
        if ({a, e, r} !== {ea, ee, er} || lat != el) begin
          tests_failed++;
          $display("[TB] FAIL fill dut%0d w%0d: got ack=%b err=%b lat=%0d, want ack=%b err=%b lat=%0d",
                   d, w, a, e, lat, ea, ee, el);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic a, e, ea, ee;
    logic [31:0] r, er;
    int lat, el;
    // full-word write and read back, no wait states
    model_txn(0, 1'b1, 4'hF, BASE + 32'd8, 32'hDEADBEEF, ea, ee, er, el);
    do_txn(0, 1'b1, 4'hF, BASE + 32'd8, 32'hDEADBEEF, a, e, r, lat);
    model_txn(0, 1'b0, 4'hF, BASE + 32'd8, 32'd0, ea, ee, er, el);
    do_txn(0, 1'b0, 4'hF, BASE + 32'd8, 32'd0, a, e, r, lat);
    tests_run++;
    if ({a, e, r} !== {1'b1, 1'b0, 32'hDEADBEEF} || lat != 1) begin
      tests_failed++;
      $display("[TB] FAIL ws0_read: got ack=%b err=%b dat=%h lat=%0d, want ack=1 err=0 dat=deadbeef lat=1",
               a, e, r, lat);
    end
    // single byte lane merged into an existing word
    model_txn(0, 1'b1, 4'hF, BASE + 32'd12, 32'h11223344, ea, ee, er, el);
    do_txn(0, 1'b1, 4'hF, BASE + 32'd12, 32'h11223344, a, e, r, lat);
    model_txn(0, 1'b1, 4'b0010, BASE + 32'd12, 32'h0000AA00, ea, ee, er, el);
    do_txn(0, 1'b1, 4'b0010, BASE + 32'd12, 32'h0000AA00, a, e, r, lat);
    tests_run++;
    if ({a, e, r} !== {1'b1, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL lane_write: got ack=%b err=%b dat=%h, want ack=1 err=0 dat=0", a, e, r);
    end
    model_txn(0, 1'b0, 4'b0001, BASE + 32'd12, 32'd0, ea, ee, er, el);
    do_txn(0, 1'b0, 4'b0001, BASE + 32'd12, 32'd0, a, e, r, lat);
    tests_run++;
    if (r !== 32'h1122AA44 || a !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL lane_read: got dat=%h ack=%b, want 1122aa44 ack=1", r, a);
    end
    // three wait states: ack only on the fourth edge after sampling
    model_txn(1, 1'b0, 4'hF, BASE + 32'd8, 32'd0, ea, ee, er, el);
    do_txn(1, 1'b0, 4'hF, BASE + 32'd8, 32'd0, a, e, r, lat);
    tests_run++;
    if ({a, e, r} !== {1'b1, 1'b0, er} || lat != 4) begin
      tests_failed++;
      $display("[TB] FAIL ws3_latency: got ack=%b err=%b dat=%h lat=%0d, want ack=1 err=0 dat=%h lat=4",
               a, e, r, lat, er);
    end
  endtask

  // Just past the top of the window and just below its base
  task automatic test_out_of_range();
    logic a, e, ea, ee;
    logic [31:0] r, er;
    logic [31:0] bad_addr [2];
    int lat, el;
    bad_addr[0] = BASE + 32'(4 * DEPTH);
    bad_addr[1] = BASE - 32'd4;
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 2; j++) begin
        for (int w = 0; w < 2; w++) begin
          do_txn(d, w[0], 4'hF, bad_addr[j], 32'hFFFF_FFFF, a, e, r, lat);
          tests_run++;
          if ({a, e, r} !== {1'b0, 1'b1, 32'd0} || lat != ((d == 0) ? 1 : 4)) begin
            tests_failed++;
            $display("[TB] FAIL oor dut%0d addr=%h we=%0d: got ack=%b err=%b dat=%h lat=%0d, want ack=0 err=1 dat=0",
                     d, bad_addr[j], w, a, e, r, lat);
          end
        end
      end
      for (int j = 0; j < 2; j++) begin
        model_txn(d, 1'b0, 4'hF, BASE + 32'(j * (4 * DEPTH - 4)), 32'd0, ea, ee, er, el);
        do_txn(d, 1'b0, 4'hF, BASE + 32'(j * (4 * DEPTH - 4)), 32'd0, a, e, r, lat);
        tests_run++;
        if ({a, e, r} !== {ea, ee, er}) begin
          tests_failed++;
          $display("[TB] FAIL oor_unchanged dut%0d edge%0d: got dat=%h, want %h", d, j, r, er);
        end
      end
    end
  endtask

  // Aborted write (cyc dropped or reset while waiting) must leave no trace
  task automatic test_abort();
    logic a, e, ea, ee, seen;
    logic [31:0] r, er;
    int lat, el;
    model_txn(1, 1'b1, 4'hF, BASE + 32'd20, 32'h55AA1234, ea, ee, er, el);
    do_txn(1, 1'b1, 4'hF, BASE + 32'd20, 32'h55AA1234, a, e, r, lat);
    for (int mode = 0; mode < 2; mode++) begin
      seen = 1'b0;
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 1'b1, 4'hF, BASE + 32'd20, 32'hCAFEF00D);
      @(posedge clk);
      @(posedge clk);
      #1;
      if (mode == 0) begin
        drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      end else begin
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      end
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        sample(1, a, e, r);
        if (a || e) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL abort_term mode%0d: got ack/err seen=1, want 0", mode);
      end
      model_txn(1, 1'b0, 4'hF, BASE + 32'd20, 32'd0, ea, ee, er, el);
      do_txn(1, 1'b0, 4'hF, BASE + 32'd20, 32'd0, a, e, r, lat);
      tests_run++;
      if ({a, e, r} !== {1'b1, 1'b0, 32'h55AA1234}) begin
        tests_failed++;
        $display("[TB] FAIL abort_data mode%0d: got ack=%b err=%b dat=%h, want ack=1 err=0 dat=55aa1234",
                 mode, a, e, r);
      end
    end
  endtask

  // Scattered lanes and a misaligned address; outcome depends on the build
  task automatic test_align();
    logic a, e, ea, ee;
    logic [31:0] r, er;
    logic [3:0]  sels  [3];
    logic [31:0] addrs [3];
    logic [31:0] dats  [3];
    int lat, el;
    sels[0] = 4'hF;    addrs[0] = BASE + 32'd16; dats[0] = 32'h12345678;
    sels[1] = 4'b0101; addrs[1] = BASE + 32'd16; dats[1] = 32'hAABBCCDD;
    sels[2] = 4'hF;    addrs[2] = BASE + 32'd18; dats[2] = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      model_txn(0, 1'b1, sels[i], addrs[i], dats[i], ea, ee, er, el);
      do_txn(0, 1'b1, sels[i], addrs[i], dats[i], a, e, r, lat);
      tests_run++;
      if ({a, e, r} !== {ea, ee, er}) begin
        tests_failed++;
        $display("[TB] FAIL align_term%0d: got ack=%b err=%b, want ack=%b err=%b", i, a, e, ea, ee);
      end
      model_txn(0, 1'b0, 4'hF, BASE + 32'd16, 32'd0, ea, ee, er, el);
      do_txn(0, 1'b0, 4'hF, BASE + 32'd16, 32'd0, a, e, r, lat);
      tests_run++;
      if ({a, e, r} !== {ea, ee, er}) begin
        tests_failed++;
        $display("[TB] FAIL align_data%0d: got dat=%h, want %h", i, r, er);
      end
    end
  endtask

  task automatic test_random();
    logic a, e, ea, ee, we;
    logic [31:0] r, er, addr, dat;
    logic [3:0] sel;
    int lat, el, d;
    for (int i = 0; i < 80; i++) begin
      d    = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      sel  = 4'($urandom_range(0, 15));
      addr = rand_addr();
      dat  = $urandom;
      model_txn(d, we, sel, addr, dat, ea, ee, er, el);
      do_txn(d, we, sel, addr, dat, a, e, r, lat);
      tests_run++;
      if ({a, e, r} !== {ea, ee, er} || lat != el) begin
        tests_failed++;
        $display("[TB] FAIL random%0d dut%0d we=%b sel=%b addr=%h: got ack=%b err=%b dat=%h lat=%0d, want ack=%b err=%b dat=%h lat=%0d",
                 i, d, we, sel, addr, a, e, r, lat, ea, ee, er, el);
      end
    end
  endtask

  // stb held high across ack: next request starts three cycles later
  task automatic test_back_to_back();
    logic a, e, ea, ee;
    logic [31:0] r, er, rd;
    logic [3:0] pat;
    int el;
    model_txn(0, 1'b1, 4'hF, BASE + 32'd40, 32'h0BADF00D, ea, ee, er, el);
    pat = 4'b0000;
    rd  = 32'd0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 4'hF, BASE + 32'd40, 32'h0BADF00D);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      sample(0, a, e, r);
      pat[3-k] = a;
      if (k == 0) drive(0, 1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'd40, 32'd0);
      if (k == 3) rd = r;
    end
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    sample(0, a, e, r);
    tests_run++;
    if (pat !== 4'b1001 || a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ack_pattern: got %b then %b, want 1001 then 0", pat, a);
    end
    tests_run++;
    if (rd !== 32'h0BADF00D) begin
      tests_failed++;
      $display("[TB] FAIL b2b_read: got %h, want 0badf00d", rd);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_out_of_range();
    test_abort();
    test_align();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
